// File: rtl/cheri_tbre_pkg.sv
// Capability register types shared by the background revocation engine and its neighbours.
package cheri_tbre_pkg;

    typedef struct packed {
        logic       valid;
        logic [1:0] lsb;
        logic [4:0] exp;
        logic [8:0] top;
        logic [8:0] base;
        logic [2:0] otype;
        logic [5:0] cperms;
    } reg_cap_t;

    localparam reg_cap_t NULL_REG_CAP = '{
        valid:  1'b0,
        lsb:    2'b00,
        exp:    5'd24,
        top:    9'h100,
        base:   9'h000,
        otype:  3'h0,
        cperms: 6'h00
    };

endpackage

// File: rtl/cheri_tbre_ctrl.sv
// Background revocation engine sequencer: walks a capability range, loads each slot,
// waits for the revocation verdict and stores revoked slots back with the tag cleared.
//
// state      | meaning
// IDLE       | waiting for a start pulse
// LD_REQ     | cap load request held on the LSU until accepted
// LD_WAIT    | waiting for the load response
// TRVK_WAIT  | waiting for the revocation verdict on the loaded cap
// ST_REQ     | tag-cleared store-back held on the LSU until accepted
// ST_WAIT    | waiting for the store-back response
// NEXT       | advance to the next slot or terminate the sweep
module cheri_tbre_ctrl
    import cheri_tbre_pkg::*;
#(
    parameter int unsigned CntWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                tbre_start_i,
    input  logic                tbre_stop_i,
    input  logic [31:0]         tbre_start_addr_i,
    input  logic [31:0]         tbre_end_addr_i,
    output logic                tbre_busy_o,
    output logic                tbre_done_o,
    output logic [CntWidth-1:0] tbre_revoked_cnt_o,
    output logic                tbre_err_o,
    output logic                tbre_lsu_req_o,
    output logic                tbre_lsu_we_o,
    output logic [31:0]         tbre_lsu_addr_o,
    output logic [31:0]         tbre_lsu_wdata_o,
    output reg_cap_t            tbre_lsu_wcap_o,
    input  logic                lsu_tbre_req_done_i,
    input  logic                lsu_tbre_resp_valid_i,
    input  logic                lsu_tbre_resp_err_i,
    input  logic [31:0]         rf_wdata_lsu_i,
    input  reg_cap_t            rf_wcap_lsu_i,
    input  logic                tbre_trvk_en_i,
    input  logic                tbre_trvk_clrtag_i,
    input  logic                snoop_wr_i,
    input  logic [31:0]         snoop_addr_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_REQ,
        S_LD_WAIT,
        S_TRVK_WAIT,
        S_ST_REQ,
        S_ST_WAIT,
        S_NEXT
    } state_e;

    state_e                r_state;
    logic [31:0]           r_cur;
    logic [31:0]           r_end;
    logic                  r_stop;
    logic                  r_snoop_hit;
    logic [31:0]           r_ld_data;
    reg_cap_t              r_ld_cap;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;
    logic [CntWidth-1:0]   r_cnt;
    logic                  r_req;
    logic                  r_we;
    logic [31:0]           r_addr;
    logic [31:0]           r_wdata;
    reg_cap_t              r_wcap;

    logic [31:0]           w_start_cur;
    logic [31:0]           w_start_end;
    logic [32:0]           w_cur_next;
    logic                  w_snoop_match;
    logic                  w_terminate;

    assign w_start_cur   = {tbre_start_addr_i[31:3], 3'b000};
    assign w_start_end   = {tbre_end_addr_i[31:3], 3'b000};
    assign w_cur_next    = {1'b0, r_cur} + 33'd8;
    assign w_snoop_match = snoop_wr_i && (snoop_addr_i[31:3] == r_cur[31:3]);
    // A carry out of bit 31 means the range ran off the top of the address space.
    assign w_terminate   = r_stop || tbre_stop_i || w_cur_next[32] ||
                           (w_cur_next[31:0] >= r_end);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_cur       <= '0;
            r_end       <= '0;
            r_stop      <= 1'b0;
            r_snoop_hit <= 1'b0;
            r_ld_data   <= '0;
            r_ld_cap    <= NULL_REG_CAP;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wcap      <= NULL_REG_CAP;
        end else begin
            r_done <= 1'b0;
            if ((r_state != S_IDLE) && tbre_stop_i) begin
                r_stop <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (tbre_start_i) begin
                        r_cur       <= w_start_cur;
                        r_end       <= w_start_end;
                        r_cnt       <= '0;
                        r_err       <= 1'b0;
                        r_stop      <= 1'b0;
                        r_snoop_hit <= 1'b0;
                        r_busy      <= 1'b1;
                        // An empty range falls straight through NEXT, which always terminates it.
                        if (w_start_cur >= w_start_end) begin
                            r_state <= S_NEXT;
                        end else begin
                            r_state <= S_LD_REQ;
                            r_req   <= 1'b1;
                            r_we    <= 1'b0;
                            r_addr  <= w_start_cur;
                        end
                    end
                end
                S_LD_REQ: begin
                    if (lsu_tbre_req_done_i) begin
                        r_req   <= 1'b0;
                        r_state <= S_LD_WAIT;
                        if (w_snoop_match) begin
                            r_snoop_hit <= 1'b1;
                        end
                    end
                end
                S_LD_WAIT: begin
                    if (w_snoop_match) begin
                        r_snoop_hit <= 1'b1;
                    end
                    if (lsu_tbre_resp_valid_i) begin
                        if (lsu_tbre_resp_err_i) begin
                            r_err <= 1'b1;
                        end else begin
                            r_ld_data <= rf_wdata_lsu_i;
                            r_ld_cap  <= rf_wcap_lsu_i;
                        end
                        r_state <= S_TRVK_WAIT;
                    end
                end
                S_TRVK_WAIT: begin
                    if (w_snoop_match) begin
                        r_snoop_hit <= 1'b1;
                    end
                    if (tbre_trvk_en_i) begin
                        // A CPU store to the slot, even in the verdict cycle, makes the loaded cap stale.
                        if (tbre_trvk_clrtag_i && !r_snoop_hit && !w_snoop_match) begin
                            r_state      <= S_ST_REQ;
                            r_req        <= 1'b1;
                            r_we         <= 1'b1;
                            r_addr       <= r_cur;
                            r_wdata      <= r_ld_data;
                            r_wcap       <= r_ld_cap;
                            r_wcap.valid <= 1'b0;
                        end else begin
                            r_state <= S_NEXT;
                        end
                    end
                end
                S_ST_REQ: begin
                    if (lsu_tbre_req_done_i) begin
                        r_req   <= 1'b0;
                        r_we    <= 1'b0;
                        r_state <= S_ST_WAIT;
                    end
                end
                S_ST_WAIT: begin
                    if (lsu_tbre_resp_valid_i) begin
                        if (!(&r_cnt)) begin
                            r_cnt <= r_cnt + CntWidth'(1);
                        end
                        if (lsu_tbre_resp_err_i) begin
                            r_err <= 1'b1;
                        end
                        r_state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    r_snoop_hit <= 1'b0;
                    if (w_terminate) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cur   <= w_cur_next[31:0];
                        r_state <= S_LD_REQ;
                        r_req   <= 1'b1;
                        r_we    <= 1'b0;
                        r_addr  <= w_cur_next[31:0];
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign tbre_busy_o        = r_busy;
    assign tbre_done_o        = r_done;
    assign tbre_revoked_cnt_o = r_cnt;
    assign tbre_err_o         = r_err;
    assign tbre_lsu_req_o     = r_req;
    assign tbre_lsu_we_o      = r_we;
    assign tbre_lsu_addr_o    = r_addr;
    assign tbre_lsu_wdata_o   = r_wdata;
    assign tbre_lsu_wcap_o    = r_wcap;

endmodule

// File: tb/tb_cheri_tbre_ctrl.sv
// Directed bench for cheri_tbre_ctrl: a small LSU/verdict responder plus linear sweep scenarios.
module tb_cheri_tbre_ctrl;
    import cheri_tbre_pkg::*;

    localparam int CW = 16;
    localparam logic [31:0] NONE = 32'h0000_0001;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          tbre_start_i = 1'b0;
    logic          tbre_stop_i = 1'b0;
    logic [31:0]   tbre_start_addr_i = '0;
    logic [31:0]   tbre_end_addr_i = '0;
    logic          tbre_busy_o;
    logic          tbre_done_o;
    logic [CW-1:0] tbre_revoked_cnt_o;
    logic          tbre_err_o;
    logic          tbre_lsu_req_o;
    logic          tbre_lsu_we_o;
    logic [31:0]   tbre_lsu_addr_o;
    logic [31:0]   tbre_lsu_wdata_o;
    reg_cap_t      tbre_lsu_wcap_o;
    logic          lsu_tbre_req_done_i = 1'b0;
    logic          lsu_tbre_resp_valid_i = 1'b0;
    logic          lsu_tbre_resp_err_i = 1'b0;
    logic [31:0]   rf_wdata_lsu_i = '0;
    reg_cap_t      rf_wcap_lsu_i = '0;
    logic          tbre_trvk_en_i = 1'b0;
    logic          tbre_trvk_clrtag_i = 1'b0;
    logic          snoop_wr_i = 1'b0;
    logic [31:0]   snoop_addr_i = '0;

    always #5 clk_i = ~clk_i;

    cheri_tbre_ctrl #(.CntWidth(CW)) dut (
        .clk_i                 (clk_i),
        .rst_ni                (rst_ni),
        .tbre_start_i          (tbre_start_i),
        .tbre_stop_i           (tbre_stop_i),
        .tbre_start_addr_i     (tbre_start_addr_i),
        .tbre_end_addr_i       (tbre_end_addr_i),
        .tbre_busy_o           (tbre_busy_o),
        .tbre_done_o           (tbre_done_o),
        .tbre_revoked_cnt_o    (tbre_revoked_cnt_o),
        .tbre_err_o            (tbre_err_o),
        .tbre_lsu_req_o        (tbre_lsu_req_o),
        .tbre_lsu_we_o         (tbre_lsu_we_o),
        .tbre_lsu_addr_o       (tbre_lsu_addr_o),
        .tbre_lsu_wdata_o      (tbre_lsu_wdata_o),
        .tbre_lsu_wcap_o       (tbre_lsu_wcap_o),
        .lsu_tbre_req_done_i   (lsu_tbre_req_done_i),
        .lsu_tbre_resp_valid_i (lsu_tbre_resp_valid_i),
        .lsu_tbre_resp_err_i   (lsu_tbre_resp_err_i),
        .rf_wdata_lsu_i        (rf_wdata_lsu_i),
        .rf_wcap_lsu_i         (rf_wcap_lsu_i),
        .tbre_trvk_en_i        (tbre_trvk_en_i),
        .tbre_trvk_clrtag_i    (tbre_trvk_clrtag_i),
        .snoop_wr_i            (snoop_wr_i),
        .snoop_addr_i          (snoop_addr_i)
    );

    int checks = 0;
    int errors = 0;

    // Responder configuration
    logic [31:0] revoke_addr = NONE;
    logic [31:0] err_addr    = NONE;
    logic [31:0] snoop_tgt   = NONE;
    logic [31:0] stop_tgt    = NONE;
    logic [31:0] dly_addr    = NONE;
    int          dly_val     = 0;
    int          st_dly      = 0;
    logic [31:0] ld_data     = 32'h8000_1234;
    reg_cap_t    ld_cap      = '{valid: 1'b1, lsb: 2'b10, exp: 5'd3, top: 9'h1A5,
                                 base: 9'h033, otype: 3'h0, cperms: 6'h2A};
    reg_cap_t    st_cap_exp;

    // Transaction log and monitor counters
    logic        lg_we[$];
    logic [31:0] lg_addr[$];
    logic [31:0] lg_wdata[$];
    reg_cap_t    lg_wcap[$];
    int          busy_cycles = 0;
    int          done_cnt = 0;
    logic        stall_bad = 1'b0;

    // LSU and revocation-pipeline model, acting at the falling edge
    initial begin
        int          gnt_wait;
        int          need;
        int          trvk_cd;
        logic        trvk_clr_p;
        logic        resp_pend;
        logic        resp_load;
        logic [31:0] resp_addr;
        logic        in_stall;
        logic [31:0] stall_addr;
        logic        stall_we;
        gnt_wait = 0; trvk_cd = 0; trvk_clr_p = 1'b0; resp_pend = 1'b0;
        resp_load = 1'b0; resp_addr = '0; in_stall = 1'b0; stall_addr = '0; stall_we = 1'b0;
        forever begin
            @(negedge clk_i);
            lsu_tbre_req_done_i   = 1'b0;
            lsu_tbre_resp_valid_i = 1'b0;
            lsu_tbre_resp_err_i   = 1'b0;
            tbre_trvk_en_i        = 1'b0;
            tbre_trvk_clrtag_i    = 1'b0;
            snoop_wr_i            = 1'b0;
            snoop_addr_i          = '0;
            tbre_stop_i           = 1'b0;
            if (!rst_ni) begin
                gnt_wait = 0; trvk_cd = 0; resp_pend = 1'b0; in_stall = 1'b0;
                continue;
            end
            if (tbre_busy_o) busy_cycles++;
            if (tbre_done_o) done_cnt++;
            if (trvk_cd > 0) begin
                trvk_cd--;
                if (trvk_cd == 0) begin
                    tbre_trvk_en_i     = 1'b1;
                    tbre_trvk_clrtag_i = trvk_clr_p;
                end else if (trvk_cd == 1 && resp_addr == snoop_tgt) begin
                    snoop_wr_i   = 1'b1;
                    snoop_addr_i = snoop_tgt + 32'd4;
                end
            end
            if (resp_pend) begin
                resp_pend = 1'b0;
                lsu_tbre_resp_valid_i = 1'b1;
                if (resp_load) begin
                    lsu_tbre_resp_err_i = (resp_addr == err_addr);
                    rf_wdata_lsu_i      = ld_data;
                    rf_wcap_lsu_i       = ld_cap;
                    trvk_cd             = 3;
                    trvk_clr_p          = (resp_addr == revoke_addr) && !lsu_tbre_resp_err_i;
                    if (resp_addr == stop_tgt) tbre_stop_i = 1'b1;
                end
            end
            if (tbre_lsu_req_o) begin
                if (in_stall && (tbre_lsu_addr_o != stall_addr || tbre_lsu_we_o != stall_we))
                    stall_bad = 1'b1;
                need = tbre_lsu_we_o ? st_dly : ((tbre_lsu_addr_o == dly_addr) ? dly_val : 0);
                if (gnt_wait >= need) begin
                    lsu_tbre_req_done_i = 1'b1;
                    lg_we.push_back(tbre_lsu_we_o);
                    lg_addr.push_back(tbre_lsu_addr_o);
                    lg_wdata.push_back(tbre_lsu_wdata_o);
                    lg_wcap.push_back(tbre_lsu_wcap_o);
                    resp_pend = 1'b1;
                    resp_load = !tbre_lsu_we_o;
                    resp_addr = tbre_lsu_addr_o;
                    gnt_wait  = 0;
                    in_stall  = 1'b0;
                end else begin
                    gnt_wait++;
                    in_stall   = 1'b1;
                    stall_addr = tbre_lsu_addr_o;
                    stall_we   = tbre_lsu_we_o;
                end
            end else if (in_stall) begin
                stall_bad = 1'b1;
            end
        end
    end

    task automatic step();
        @(negedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_txn(input string tag, input int idx, input logic we, input logic [31:0] addr);
        logic [63:0] obs;
        obs = 64'hDEAD_0000_0000;
        if (idx < lg_addr.size()) obs = {31'b0, lg_we[idx], lg_addr[idx]};
        chk(tag, obs, {31'b0, we, addr});
    endtask

    task automatic cfg_clear();
        revoke_addr = NONE; err_addr = NONE; snoop_tgt = NONE; stop_tgt = NONE;
        dly_addr = NONE; dly_val = 0; st_dly = 0;
    endtask

    task automatic start_sweep(input logic [31:0] s, input logic [31:0] e);
        step();
        lg_we.delete(); lg_addr.delete(); lg_wdata.delete(); lg_wcap.delete();
        busy_cycles = 0; done_cnt = 0; stall_bad = 1'b0;
        tbre_start_addr_i = s;
        tbre_end_addr_i   = e;
        tbre_start_i      = 1'b1;
        step();
        tbre_start_i      = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int maxc);
        int n;
        n = 0;
        while (!tbre_done_o && n < maxc) begin
            step();
            n++;
        end
        chk(tag, 64'(tbre_done_o), 64'd1);
        repeat (3) step();
    endtask

    initial begin
        st_cap_exp = ld_cap;
        st_cap_exp.valid = 1'b0;
        repeat (3) step();
        chk("rst_busy",  64'(tbre_busy_o), 64'd0);
        chk("rst_done",  64'(tbre_done_o), 64'd0);
        chk("rst_req",   64'(tbre_lsu_req_o), 64'd0);
        chk("rst_we",    64'(tbre_lsu_we_o), 64'd0);
        chk("rst_err",   64'(tbre_err_o), 64'd0);
        chk("rst_cnt",   64'(tbre_revoked_cnt_o), 64'd0);
        chk("rst_addr",  64'(tbre_lsu_addr_o), 64'd0);
        chk("rst_wdata", 64'(tbre_lsu_wdata_o), 64'd0);
        chk("rst_wcap",  64'(tbre_lsu_wcap_o), 64'(NULL_REG_CAP));
        rst_ni = 1'b1;
        step();

        // Plain sweep of four slots, nothing revoked
        cfg_clear();
        start_sweep(32'h8000_0000, 32'h8000_0020);
        wait_done("t1_done_seen", 200);
        chk("t1_ntxn", 64'(lg_addr.size()), 64'd4);
        chk_txn("t1_txn0", 0, 1'b0, 32'h8000_0000);
        chk_txn("t1_txn1", 1, 1'b0, 32'h8000_0008);
        chk_txn("t1_txn2", 2, 1'b0, 32'h8000_0010);
        chk_txn("t1_txn3", 3, 1'b0, 32'h8000_0018);
        chk("t1_cnt",   64'(tbre_revoked_cnt_o), 64'd0);
        chk("t1_err",   64'(tbre_err_o), 64'd0);
        chk("t1_ndone", 64'(done_cnt), 64'd1);
        chk("t1_busy",  64'(busy_cycles), 64'd24);

        // Slot 0x08 revoked: one store-back with tag cleared
        cfg_clear();
        revoke_addr = 32'h8000_0008;
        start_sweep(32'h8000_0000, 32'h8000_0020);
        wait_done("t2_done_seen", 200);
        chk("t2_ntxn", 64'(lg_addr.size()), 64'd5);
        chk_txn("t2_txn1", 1, 1'b0, 32'h8000_0008);
        chk_txn("t2_store", 2, 1'b1, 32'h8000_0008);
        chk_txn("t2_txn3", 3, 1'b0, 32'h8000_0010);
        chk_txn("t2_txn4", 4, 1'b0, 32'h8000_0018);
        chk("t2_wdata", (lg_wdata.size() > 2) ? 64'(lg_wdata[2]) : 64'hDEAD, 64'h8000_1234);
        chk("t2_wcap",  (lg_wcap.size() > 2) ? 64'(lg_wcap[2]) : 64'hDEAD, 64'(st_cap_exp));
        chk("t2_cnt",   64'(tbre_revoked_cnt_o), 64'd1);
        chk("t2_busy",  64'(busy_cycles), 64'd26);
        chk("t2_ndone", 64'(done_cnt), 64'd1);

        // Revoked slot overwritten by the CPU during the verdict wait
        cfg_clear();
        revoke_addr = 32'h8000_0010;
        snoop_tgt   = 32'h8000_0010;
        start_sweep(32'h8000_0000, 32'h8000_0020);
        wait_done("t3_done_seen", 200);
        chk("t3_ntxn", 64'(lg_addr.size()), 64'd4);
        chk_txn("t3_txn2", 2, 1'b0, 32'h8000_0010);
        chk_txn("t3_txn3", 3, 1'b0, 32'h8000_0018);
        chk("t3_cnt",  64'(tbre_revoked_cnt_o), 64'd0);
        chk("t3_busy", 64'(busy_cycles), 64'd24);

        // Empty range: start == end
        cfg_clear();
        start_sweep(32'h9000_0000, 32'h9000_0000);
        chk("t4a_busy1", 64'(tbre_busy_o), 64'd1);
        chk("t4a_done1", 64'(tbre_done_o), 64'd0);
        step();
        chk("t4a_busy2", 64'(tbre_busy_o), 64'd0);
        chk("t4a_done2", 64'(tbre_done_o), 64'd1);
        step();
        chk("t4a_done3", 64'(tbre_done_o), 64'd0);
        repeat (3) step();
        chk("t4a_ntxn",  64'(lg_addr.size()), 64'd0);
        chk("t4a_bcyc",  64'(busy_cycles), 64'd1);
        chk("t4a_ndone", 64'(done_cnt), 64'd1);

        // Inverted range: start above end
        start_sweep(32'h9000_0010, 32'h9000_0000);
        wait_done("t4b_done_seen", 10);
        chk("t4b_ntxn",  64'(lg_addr.size()), 64'd0);
        chk("t4b_bcyc",  64'(busy_cycles), 64'd1);
        chk("t4b_ndone", 64'(done_cnt), 64'd1);

        // Stop during the load wait of a revoked slot: store-back completes, then terminate
        cfg_clear();
        revoke_addr = 32'h8000_0008;
        stop_tgt    = 32'h8000_0008;
        start_sweep(32'h8000_0000, 32'h8000_0020);
        wait_done("t5_done_seen", 200);
        repeat (5) step();
        chk("t5_ntxn", 64'(lg_addr.size()), 64'd3);
        chk_txn("t5_store", 2, 1'b1, 32'h8000_0008);
        chk("t5_cnt",   64'(tbre_revoked_cnt_o), 64'd1);
        chk("t5_busy",  64'(busy_cycles), 64'd14);
        chk("t5_ndone", 64'(done_cnt), 64'd1);

        // Load error on slot 2 with a 5-cycle grant stall
        cfg_clear();
        err_addr = 32'h8000_0010;
        dly_addr = 32'h8000_0010;
        dly_val  = 5;
        start_sweep(32'h8000_0000, 32'h8000_0020);
        wait_done("t6_done_seen", 200);
        chk("t6_ntxn",  64'(lg_addr.size()), 64'd4);
        chk_txn("t6_txn2", 2, 1'b0, 32'h8000_0010);
        chk_txn("t6_txn3", 3, 1'b0, 32'h8000_0018);
        chk("t6_stall", 64'(stall_bad), 64'd0);
        chk("t6_err",   64'(tbre_err_o), 64'd1);
        chk("t6_cnt",   64'(tbre_revoked_cnt_o), 64'd0);
        chk("t6_busy",  64'(busy_cycles), 64'd29);

        // Reset asserted while a store-back is stalled in ST_REQ
        cfg_clear();
        revoke_addr = 32'h8000_0000;
        st_dly      = 1000;
        start_sweep(32'h8000_0000, 32'h8000_0020);
        begin
            int n;
            n = 0;
            while (!(tbre_lsu_req_o && tbre_lsu_we_o) && n < 100) begin
                step();
                n++;
            end
        end
        chk("t7_in_streq", 64'({tbre_lsu_req_o, tbre_lsu_we_o}), 64'd3);
        step();
        rst_ni = 1'b0;
        #1;
        chk("t7_busy",  64'(tbre_busy_o), 64'd0);
        chk("t7_req",   64'(tbre_lsu_req_o), 64'd0);
        chk("t7_we",    64'(tbre_lsu_we_o), 64'd0);
        chk("t7_addr",  64'(tbre_lsu_addr_o), 64'd0);
        chk("t7_wdata", 64'(tbre_lsu_wdata_o), 64'd0);
        chk("t7_wcap",  64'(tbre_lsu_wcap_o), 64'(NULL_REG_CAP));
        chk("t7_done",  64'(tbre_done_o), 64'd0);
        chk("t7_cnt",   64'(tbre_revoked_cnt_o), 64'd0);
        repeat (2) step();
        rst_ni = 1'b1;
        st_dly = 0;
        repeat (10) step();
        chk("t7_ndone", 64'(done_cnt), 64'd0);
        chk("t7_idle",  64'({tbre_busy_o, tbre_lsu_req_o}), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
